seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Multi-cycle, bit-serial counterpart of the team's combinational 8-bit barrel shifter.
- Accepts an operand with shift amount, direction (LR) and arithmetic/logical (AL) selects over a valid/ready handshake.
- Shifts one bit position per clock and returns the result over a second valid/ready handshake.
- Used where area matters more than latency; also serves as a golden sequential model when cross-checking the barrel shifter on the board.

Parameters:
- WIDTH, 8, operand/result width in bits.
- SHW, 3, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request; high only in IDLE.
- din  input  WIDTH  operand.
- shamt  input  SHW  shift amount, 0..WIDTH-1.
- LR  input  1  direction: 0 = right, 1 = left.
- AL  input  1  right-shift fill: 1 = arithmetic (replicate din[MSB]), 0 = logical (zero fill); ignored for left shifts.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- dout  output  WIDTH  shift result, registered.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (synchronous, active-high, sampled on clk rising edge): state=IDLE, dout=0, cnt=0, out_valid=0, busy=0, in_ready=1. Reset in any state aborts the operation; no result is emitted.
- States are IDLE, SHIFT and DONE. in_ready, out_valid and busy decode directly from the state register.
- IDLE, accept (in_valid && in_ready):
  - Capture din into the working register and latch LR, AL and cnt=shamt.
  - Next state is SHIFT if shamt!=0, otherwise DONE.
  - IDLE without in_valid: hold.
- SHIFT, each cycle:
  - LR=1: reg <= {reg[WIDTH-2:0], 1'b0}.
  - LR=0: reg <= {fill, reg[WIDTH-1:1]}, where fill = AL ? reg[WIDTH-1] : 0.
  - cnt <= cnt-1. When cnt==1 in the current cycle, go to DONE.
- DONE:
  - out_valid=1 and dout = working register, held stable while out_ready=0.
  - out_valid && out_ready: go to IDLE.
  - in_valid is ignored in DONE. There is no overlap of accept and output handshakes; in_ready rises the cycle after the output handshake.
- Latency: out_valid rises shamt+1 cycles after the accept edge (shamt=0: 1 cycle).
- Throughput: one operation per shamt+2 cycles minimum.
- Input signals changing while busy have no effect; all are latched at accept.
- shamt=WIDTH-1 (max) works as normal. No shift larger than WIDTH-1 is representable.
- dout keeps the last result after returning to IDLE until the next result; it is 0 only after reset.

Test Plan:
- Arithmetic right: din=8'h96, shamt=3, LR=0, AL=1 -> out_valid 4 cycles after accept, dout=8'hF2.
- Logical right / left: din=8'h96, shamt=3, LR=0, AL=0 -> dout=8'h12. Same din with LR=1 -> dout=8'hB0 (AL=1 gives the same result).
- Zero and max shifts:
  - shamt=0, din=8'h5A -> dout=8'h5A, 1-cycle latency.
  - din=8'h80, shamt=7, LR=0, AL=1 -> 8'hFF; with AL=0 -> 8'h01.
  - din=8'h01, shamt=7, LR=1 -> 8'h80.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and din -> dout, out_valid stable, in_ready=0, no new accept. out_ready=1 -> IDLE next cycle.
- Reset mid-operation: assert rst for one cycle during SHIFT (shamt=5) -> next cycle state IDLE, out_valid=0, dout=0, in_ready=1. A subsequent request completes correctly.
- Back-to-back randomized ops (≥1000): compare against the reference model (>>, >>>, << on WIDTH bits). Check latency is exactly shamt+1 every time.

Source files
------------

// File: rtl/seq_shifter.sv
// seq_shifter: bit-serial shifter, one bit position per clock.
// An operand is accepted over a valid/ready handshake, shifted left, or
// logically/arithmetically right, and the result is returned over a second
// valid/ready handshake. IDLE -> SHIFT (shamt cycles) -> DONE -> IDLE.
module seq_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic             LR,
    input  logic             AL,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
    localparam logic [SHW-1:0] CNT_ZERO = SHW'(0);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             lr_q, lr_d;
    logic             al_q, al_d;
    logic             fill_s;

    // Next-state, datapath and result-register update for each state.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        lr_d    = lr_q;
        al_d    = al_q;
        // Arithmetic fill re-uses the current MSB, which never changes during
        // a right shift, so it always equals the captured operand's sign bit.
        fill_s  = al_q ? work_q[WIDTH-1] : 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d = din;
                    lr_d   = LR;
                    al_d   = AL;
                    cnt_d  = shamt;
                    if (shamt != CNT_ZERO) begin
                        state_d = ST_SHIFT;
                    end else begin
                        // Zero shift: result is the operand itself.
                        state_d = ST_DONE;
                        dout_d  = din;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (lr_q) begin
                    work_d = {work_q[WIDTH-2:0], 1'b0};
                end else begin
                    work_d = {fill_s, work_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    // Last shift: publish the final value into the result register.
                    state_d = ST_DONE;
                    dout_d  = work_d;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // in_valid is deliberately ignored here; no accept/result overlap.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= {WIDTH{1'b0}};
            dout_q  <= {WIDTH{1'b0}};
            cnt_q   <= CNT_ZERO;
            lr_q    <= 1'b0;
            al_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            lr_q    <= lr_d;
            al_q    <= al_d;
        end
    end

    // Handshake/status outputs decode directly from the state register.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
        dout      = dout_q;
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed cases, backpressure,
// mid-operation reset and randomized back-to-back operations compared
// against a plain-arithmetic reference model.
module tb_seq_shifter;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic [SHW-1:0]   shamt;
    logic             LR;
    logic             AL;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic             busy;

    int checks = 0;
    int errors = 0;

    seq_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din      (din),
        .shamt    (shamt),
        .LR       (LR),
        .AL       (AL),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (dout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model: the shift expressed with the language's shift operators.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                   input int sh,
                                                   input logic lr,
                                                   input logic al);
        logic signed [WIDTH-1:0] sd;
        sd = d;
        if (lr)      return d << sh;
        else if (al) return sd >>> sh;
        else         return d >> sh;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Perform one operation; hold = cycles of out_ready low in DONE.
    task automatic do_op(input logic [WIDTH-1:0] d, input int sh, input logic lr,
                         input logic al, input logic [WIDTH-1:0] exp_v,
                         input int hold, input string name);
        int n;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_before_accept: got %b want 1", name, in_ready);
        end
        in_valid = 1'b1;
        din      = d;
        shamt    = SHW'(sh);
        LR       = lr;
        AL       = al;
        tick();
        // Scramble inputs after accept; they must have no effect.
        in_valid = 1'b0;
        din      = WIDTH'($urandom);
        shamt    = SHW'($urandom);
        LR       = 1'($urandom);
        AL       = 1'($urandom);
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy_in_shift: got %b want 1", name, busy);
            end
            tick();
            n++;
        end
        checks++;
        if (n !== sh + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, n, sh + 1);
        end
        checks++;
        if (dout !== exp_v) begin
            errors++;
            $display("FAIL %s dout: got %h want %h", name, dout, exp_v);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            tick();
            checks++;
            if (out_valid !== 1'b1 || dout !== exp_v || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold: out_valid=%b dout=%h in_ready=%b want 1 %h 0",
                         name, out_valid, dout, exp_v, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || dout !== exp_v) begin
            errors++;
            $display("FAIL %s return_idle: in_ready=%b out_valid=%b busy=%b dout=%h want 1 0 0 %h",
                     name, in_ready, out_valid, busy, dout, exp_v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || dout !== 8'h00) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b dout=%h want 1 0 0 00",
                     in_ready, out_valid, busy, dout);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        do_op(8'h96, 3, 1'b0, 1'b1, 8'hF2, 0, "asr3");
        do_op(8'h96, 3, 1'b0, 1'b0, 8'h12, 0, "lsr3");
        do_op(8'h96, 3, 1'b1, 1'b0, 8'hB0, 0, "lsl3");
        do_op(8'h96, 3, 1'b1, 1'b1, 8'hB0, 0, "lsl3_al");
        do_op(8'h5A, 0, 1'b0, 1'b1, 8'h5A, 0, "zero");
        do_op(8'h80, 7, 1'b0, 1'b1, 8'hFF, 0, "asr7");
        do_op(8'h80, 7, 1'b0, 1'b0, 8'h01, 0, "lsr7");
        do_op(8'h01, 7, 1'b1, 1'b0, 8'h80, 0, "lsl7");
    endtask

    task automatic test_backpressure();
        do_op(8'hC3, 2, 1'b0, 1'b1, 8'hF0, 5, "backpressure");
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        din      = 8'hA5;
        shamt    = 3'd5;
        LR       = 1'b1;
        AL       = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b dout=%h want 1 0 0 00",
                     in_ready, out_valid, busy, dout);
        end
        // No stray result must appear afterwards.
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_result: out_valid=%b want 0", out_valid);
            end
        end
        do_op(8'h3C, 4, 1'b0, 1'b0, 8'h03, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] d;
        int               sh;
        logic             lr;
        logic             al;
        for (int k = 0; k < 1000; k++) begin
            d  = WIDTH'($urandom);
            sh = int'($urandom_range(0, WIDTH - 1));
            lr = 1'($urandom);
            al = 1'($urandom);
            do_op(d, sh, lr, al, ref_shift(d, sh, lr, al),
                  int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        din       = 8'h00;
        shamt     = 3'd0;
        LR        = 1'b0;
        AL        = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
